// File: rtl/ula_mul_sequencer_if.sv
// Handshake and ULA-drive bundle between the multiply sequencer, the microsequencer and the ULA.
// slave is the sequencer side; master is the microsequencer/ULA side.
interface ula_mul_sequencer_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        res_n;
  logic        res_z;
  logic [31:0] ula_a;
  logic [31:0] ula_b;
  logic [5:0]  ula_sel;
  logic [31:0] ula_out;
  logic        ula_n;
  logic        ula_z;

  modport slave (
    input  start, op_a, op_b, ula_out, ula_n, ula_z,
    output busy, done, result, res_n, res_z, ula_a, ula_b, ula_sel
  );

  modport master (
    output start, op_a, op_b, ula_out, ula_n, ula_z,
    input  busy, done, result, res_n, res_z, ula_a, ula_b, ula_sel
  );
endinterface

// File: rtl/ula_mul_sequencer.sv
// Shift-and-add multiply controller driving the shared 32-bit ULA; low 32 bits of A*B.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module ula_mul_sequencer #(
  parameter int unsigned ITER      = 32,
  parameter logic [5:0]  SEL_ADD   = 6'b111100,
  parameter logic [5:0]  SEL_PASSB = 6'b010100,
  parameter logic [5:0]  SEL_ZERO  = 6'b010000
) (
  input logic               clk,
  input logic               rst_n,
  ula_mul_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StStep, StFin} state_e;

  state_e      state_q;
  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [5:0]  cnt_q;
  logic [31:0] result_q;
  logic        res_n_q;
  logic        res_z_q;
  logic        done_q;
  logic        last_step;

`ifdef MUL_EARLY_EXIT_EN
  assign last_step = (cnt_q == 6'(ITER - 1)) || ((mplier_q >> 1) == 32'd0);
`else
  assign last_step = (cnt_q == 6'(ITER - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      res_n_q  <= 1'b0;
      res_z_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) state_q <= StLoad;
        end
        StLoad: begin
          // ULA is on SEL_ZERO here, so acc starts from a clean 0
          acc_q    <= bus.ula_out;
          mcand_q  <= bus.op_a;
          mplier_q <= bus.op_b;
          cnt_q    <= '0;
`ifdef MUL_EARLY_EXIT_EN
          state_q  <= (bus.op_b == 32'd0) ? StFin : StStep;
`else
          state_q  <= StStep;
`endif
        end
        StStep: begin
          acc_q    <= bus.ula_out;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 6'd1;
          if (last_step) state_q <= StFin;
        end
        StFin: begin
          // ULA passes acc through so the flags describe the final product
          result_q <= bus.ula_out;
          res_n_q  <= bus.ula_n;
          res_z_q  <= bus.ula_z;
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.ula_a   = '0;
    bus.ula_b   = acc_q;
    bus.ula_sel = SEL_PASSB;
    unique case (state_q)
      StLoad: begin
        bus.ula_b   = '0;
        bus.ula_sel = SEL_ZERO;
      end
      StStep: begin
        bus.ula_a   = mcand_q;
        bus.ula_sel = mplier_q[0] ? SEL_ADD : SEL_PASSB;
      end
      default: ;
    endcase
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.res_n  = res_n_q;
  assign bus.res_z  = res_z_q;

endmodule

// File: tb/tb_ula_mul_sequencer.sv
// Bench for ula_mul_sequencer: behavioural ULA, directed and random multiplies vs. arithmetic model.
module tb_ula_mul_sequencer;
  localparam int unsigned ITER      = 32;
  localparam logic [5:0]  SEL_ADD   = 6'b111100;
  localparam logic [5:0]  SEL_PASSB = 6'b010100;
  localparam logic [5:0]  SEL_ZERO  = 6'b010000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ula_mul_sequencer_if bus ();

  ula_mul_sequencer #(
    .ITER     (ITER),
    .SEL_ADD  (SEL_ADD),
    .SEL_PASSB(SEL_PASSB),
    .SEL_ZERO (SEL_ZERO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ULA model
  logic [31:0] ula_res;
  always_comb begin
    unique case (bus.ula_sel)
      SEL_ADD:   ula_res = bus.ula_a + bus.ula_b;
      SEL_PASSB: ula_res = bus.ula_b;
      SEL_ZERO:  ula_res = 32'd0;
      default:   ula_res = 32'hDEAD_BEEF;
    endcase
  end
  assign bus.ula_out = ula_res;
  assign bus.ula_n   = ula_res[31];
  assign bus.ula_z   = (ula_res == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] bm;
    bm = (ITER >= 32) ? b : (b & ((32'd1 << ITER) - 32'd1));
    p  = {32'd0, a} * {32'd0, bm};
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int msb;
    if (b == 32'd0) return 2;
    msb = 0;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    return 2 + (((msb + 1) < int'(ITER)) ? (msb + 1) : int'(ITER));
`else
    return int'(ITER) + 2;
`endif
  endfunction

  // Issue one multiply; hold keeps start high throughout, pulse_at raises start mid-run.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                       input int pulse_at);
    int          k;
    int          exp_k;
    bit          busy_ok;
    bit          seen;
    logic [31:0] exp_r;
    exp_r = ref_mul(a, b);
    exp_k = ref_lat(b);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    k       = 0;
    busy_ok = 1'b1;
    seen    = 1'b0;
    while (!seen && k < 400) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_ok = 1'b0;
      if (k == 1) begin
        bus.op_a = $urandom;
        bus.op_b = $urandom;
      end
      if (k == pulse_at) bus.start = 1'b1;
      else if (!hold && k == pulse_at + 1) bus.start = 1'b0;
      @(negedge clk);
      k++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(k), 32'(exp_k));
    chk("busy_during_op", 32'(busy_ok), 32'd1);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    chk("result", bus.result, exp_r);
    chk("res_n", 32'(bus.res_n), 32'(exp_r[31]));
    chk("res_z", 32'(bus.res_z), 32'(exp_r == 32'd0));
    if (!hold) begin
      @(negedge clk);
      chk("done_pulse_len", 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    bit          quiet;
    logic [31:0] ra;
    logic [31:0] rb;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_res_n", 32'(bus.res_n), 32'd0);
    chk("rst_res_z", 32'(bus.res_z), 32'd0);
    chk("rst_ula_sel", 32'(bus.ula_sel), 32'(SEL_PASSB));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'd7, 32'd6, 1'b0, -1);
    do_op(32'hFFFF_FFFF, 32'd5, 1'b0, -1);
    do_op(32'h0001_0000, 32'h0001_0000, 1'b0, -1);
    do_op(32'd3, 32'd2, 1'b0, -1);
    do_op(32'd12345, 32'd0, 1'b0, -1);
    do_op(32'h8000_0001, 32'hFFFF_FFFF, 1'b0, -1);

    // start pulse mid-run must not queue a second op
    do_op(32'd9, 32'd11, 1'b0, 10);
    quiet = 1'b1;
    repeat (ITER + 6) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    chk("ignored_start", 32'(quiet), 32'd1);

    // back-to-back: start held through done launches the next op immediately
    do_op(32'd100, 32'd200, 1'b1, -1);
    do_op(32'hCAFE_0001, 32'd77, 1'b0, -1);

    // mid-run reset aborts and clears the result
    bus.op_a  = 32'd5;
    bus.op_b  = 32'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (ITER + 6) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    chk("abort_no_done", 32'(quiet), 32'd1);
    do_op(32'd13, 32'd17, 1'b0, -1);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      do_op(ra, rb, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
